// File: rtl/amount_display.sv
// amount_display: binary coin total -> BCD (double-dabble) -> 4-digit
// multiplexed active-low seven-segment display with leading-zero blanking.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high
//   change  in   one-cycle strobe, amount valid in the same cycle
//   amount  in   [7:0] binary total 0..255
//   seg     out  [6:0] segments {g,f,e,d,c,b,a}, active-low, registered
//   an      out  [3:0] anodes, active-low, registered (an[3] always off)
//   dp      out  decimal point, constant off
//   busy    out  high while a conversion is running

module amount_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change,
    input  logic [7:0] amount,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state_q;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] disp_bcd_q;
    logic [2:0]  iter_q;
    logic        pending_q;

    logic [CW-1:0] scan_q;
    logic [1:0]    digit_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;

    logic [11:0] bcd_adj;
    logic [11:0] bcd_d;
    logic [7:0]  bin_d;
    logic [6:0]  seg_d;
    logic [3:0]  an_d;

    // One double-dabble step: correct every nibble >= 5, then shift
    // {bcd, bin} left. Running the correction ahead of each shift makes the
    // usual post-shift correction after the last shift unnecessary.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
    end

    // Conversion FSM. A rerun requested during a conversion (pending, or a
    // strobe on the last shift) restarts straight from the commit edge so
    // busy never drops between back-to-back conversions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            disp_bcd_q <= '0;
            iter_q     <= '0;
            pending_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (change) begin
                        bin_q   <= amount;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bin_q  <= bin_d;
                    bcd_q  <= bcd_d;
                    iter_q <= iter_q + 3'd1;
                    if (change) begin
                        pending_q <= 1'b1;
                    end
                    if (iter_q == 3'd7) begin
                        disp_bcd_q <= bcd_d;
                        if (pending_q || change) begin
                            bin_q     <= amount;
                            bcd_q     <= '0;
                            iter_q    <= '0;
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
    logic       hund_blank;
    logic       tens_blank;

    assign hund  = disp_bcd_q[11:8];
    assign tens  = disp_bcd_q[7:4];
    assign units = disp_bcd_q[3:0];
    assign hund_blank = (hund == 4'd0);
    assign tens_blank = hund_blank && (tens == 4'd0);

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        unique case (digit_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = decode(units);
            end
            2'd1: begin
                if (!tens_blank) begin
                    an_d  = 4'b1101;
                    seg_d = decode(tens);
                end
            end
            2'd2: begin
                if (!hund_blank) begin
                    an_d  = 4'b1011;
                    seg_d = decode(hund);
                end
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = SEG_OFF;
            end
        endcase
    end

    // Scan: slot index advances on counter wrap; outputs are registered
    // from the current slot so seg and an always switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q  <= '0;
            digit_q <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= 4'b1111;
        end else begin
            if (scan_q == SCAN_LAST) begin
                scan_q  <= '0;
                digit_q <= digit_q + 2'd1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;
    assign busy = (state_q == CONV);

endmodule

// File: tb/tb_amount_display.sv
// tb_amount_display: randomized self-checking bench for amount_display
// against an arithmetic reference model of the BCD display.

module tb_amount_display;

    localparam int DIV = 4;
    localparam logic [6:0] DEC [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       change = 1'b0;
    logic [7:0] amount = 8'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;

    logic [3:0] obs_an [16];
    logic [6:0] obs_seg [16];
    int         obs_slot [16];

    amount_display #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .change (change),
        .amount (amount),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; outputs after edge n show slot
    // ((n-1)/DIV) % 4.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic void exp_slot(input int v, input int s,
                                     output logic [3:0] a,
                                     output logic [6:0] g);
        a = 4'b1111;
        g = 7'h7F;
        if (s == 0) begin
            a = 4'b1110;
            g = DEC[v % 10];
        end else if (s == 1 && v >= 10) begin
            a = 4'b1101;
            g = DEC[(v / 10) % 10];
        end else if (s == 2 && v >= 100) begin
            a = 4'b1011;
            g = DEC[v / 100];
        end
    endfunction

    task automatic kick(input int v);
        @(negedge clk);
        amount = v[7:0];
        change = 1'b1;
        @(negedge clk);
        change = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic capture_frame();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs_an[k]   = an;
            obs_seg[k]  = seg;
            obs_slot[k] = ((cyc - 1) / DIV) % 4;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: an=%h seg=%h dp=%b want F 7F 1",
                     an, seg, dp);
        end
        reset = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: an=%h seg=%h busy=%b want F 7F 0",
                     an, seg, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (an !== 4'hE || seg !== 7'h40 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first: an=%h seg=%h busy=%b want E 40 0",
                     an, seg, busy);
        end
    endtask

    task automatic test_137();
        int n;
        logic [3:0] ea;
        logic [6:0] eg;
        kick(137);
        wait_idle(n);
        n_checks++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL busy_137: cycles=%0d want 8", n);
        end
        n_checks++;
        if (dut.disp_bcd_q !== 12'h137) begin
            n_fail++;
            $display("FAIL bcd_137: got %h want 137", dut.disp_bcd_q);
        end
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            exp_slot(137, obs_slot[k], ea, eg);
            n_checks++;
            if (obs_an[k] !== ea || obs_seg[k] !== eg) begin
                n_fail++;
                $display("FAIL frame_137[%0d]: an=%h seg=%h want an=%h seg=%h",
                         k, obs_an[k], obs_seg[k], ea, eg);
            end
        end
    endtask

    task automatic test_blanking();
        int vals [4] = '{5, 40, 255, 0};
        int n;
        logic [3:0] ea;
        logic [6:0] eg;
        foreach (vals[i]) begin
            kick(vals[i]);
            wait_idle(n);
            n_checks++;
            if (dut.disp_bcd_q !== ref_bcd(vals[i])) begin
                n_fail++;
                $display("FAIL bcd_%0d: got %h want %h", vals[i],
                         dut.disp_bcd_q, ref_bcd(vals[i]));
            end
            capture_frame();
            for (int k = 0; k < 16; k++) begin
                exp_slot(vals[i], obs_slot[k], ea, eg);
                n_checks++;
                if (obs_an[k] !== ea || obs_seg[k] !== eg) begin
                    n_fail++;
                    $display("FAIL blank_%0d[%0d]: an=%h seg=%h want an=%h seg=%h",
                             vals[i], k, obs_an[k], obs_seg[k], ea, eg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int m;
        logic [3:0] ea;
        logic [6:0] eg;
        kick(10);
        for (int k = 0; k < 60; k++) begin
            if (!busy) break;
            n++;
            change = (k == 2);
            if (k == 2) amount = 8'd20;
            @(negedge clk);
        end
        change = 1'b0;
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL b2b_busy: cycles=%0d want 16", n);
        end
        wait_idle(m);
        n_checks++;
        if (dut.disp_bcd_q !== 12'h020) begin
            n_fail++;
            $display("FAIL b2b_bcd: got %h want 020", dut.disp_bcd_q);
        end
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            exp_slot(20, obs_slot[k], ea, eg);
            n_checks++;
            if (obs_an[k] !== ea || obs_seg[k] !== eg) begin
                n_fail++;
                $display("FAIL b2b_frame[%0d]: an=%h seg=%h want an=%h seg=%h",
                         k, obs_an[k], obs_seg[k], ea, eg);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [3:0] ea;
        logic [6:0] eg;
        kick(200);
        @(negedge clk);
        amount = 8'd77;
        change = 1'b1;
        @(negedge clk);
        change = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || dut.pending_q !== 1'b0 ||
            dut.disp_bcd_q !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_conv: busy=%b pending=%b bcd=%h want 0 0 000",
                     busy, dut.pending_q, dut.disp_bcd_q);
        end
        @(negedge clk);
        reset = 1'b0;
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            exp_slot(0, obs_slot[k], ea, eg);
            n_checks++;
            if (obs_an[k] !== ea || obs_seg[k] !== eg) begin
                n_fail++;
                $display("FAIL reset_conv_frame[%0d]: an=%h seg=%h want an=%h seg=%h",
                         k, obs_an[k], obs_seg[k], ea, eg);
            end
        end
    endtask

    task automatic test_sweep();
        int order [256];
        int j;
        int t;
        int n;
        foreach (order[i]) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        foreach (order[i]) begin
            kick(order[i]);
            wait_idle(n);
            n_checks++;
            if (n !== 8 || dut.disp_bcd_q !== ref_bcd(order[i])) begin
                n_fail++;
                $display("FAIL sweep_%0d: cycles=%0d bcd=%h want 8 %h",
                         order[i], n, dut.disp_bcd_q, ref_bcd(order[i]));
            end
        end
    endtask

    task automatic test_random_strobes();
        int last;
        int n;
        int len;
        logic [3:0] ea;
        logic [6:0] eg;
        for (int it = 0; it < 15; it++) begin
            last = int'($urandom_range(0, 255));
            kick(last);
            len = int'($urandom_range(2, 14));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    last = int'($urandom_range(0, 255));
                    amount = last[7:0];
                    change = 1'b1;
                end else begin
                    change = 1'b0;
                end
                @(negedge clk);
            end
            change = 1'b0;
            wait_idle(n);
            n_checks++;
            if (n >= 100 || dut.disp_bcd_q !== ref_bcd(last)) begin
                n_fail++;
                $display("FAIL rand_%0d: cycles=%0d bcd=%h want %h",
                         it, n, dut.disp_bcd_q, ref_bcd(last));
            end
            capture_frame();
            for (int k = 0; k < 16; k++) begin
                exp_slot(last, obs_slot[k], ea, eg);
                n_checks++;
                if (obs_an[k] !== ea || obs_seg[k] !== eg) begin
                    n_fail++;
                    $display("FAIL rand_frame_%0d[%0d]: an=%h seg=%h want an=%h seg=%h",
                             it, k, obs_an[k], obs_seg[k], ea, eg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_137();
        test_blanking();
        test_back_to_back();
        test_reset_mid_conv();
        test_sweep();
        test_random_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
